psum_row_accumulator: RTL and testbench
=======================================

Name: psum_row_accumulator

Overview:
- Sits directly downstream of the 1-D convolution PE.
- Captures the PE's three partial sums (pe_out0..pe_out2) each time the PE signals done.
- Sums them element-wise across num_rows successive PE passes (vertical psum accumulation for a 2-D filter).
- Streams the finished output row, one word per transfer, over a valid/ready interface toward the output buffer.

Parameters:
- d_width, 32, width of every psum and output word.
- num_rows, 3, number of PE passes summed per output row; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- pe_done  input  1  PE done level; a rising edge (high now, low on previous clk) marks pe_out0..2 valid.
- pe_out0  input  d_width  PE partial sum, output position 0.
- pe_out1  input  d_width  PE partial sum, output position 1.
- pe_out2  input  d_width  PE partial sum, output position 2.
- out_data  output  d_width  accumulated output word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- out_last  output  1  high with the final word (position 2) of a row.
- busy  output  1  high when row_cnt != 0 or state is DRAIN.
- ovf  output  1  sticky: an accumulation carried out of d_width.
- drop  output  1  sticky: a pe_done edge arrived during DRAIN and was discarded.

Behaviour:
- Reset (rst high, asynchronous):
  - acc[0..2], out_data, row_cnt and idx clear to 0.
  - out_valid, out_last, busy, ovf and drop clear to 0.
  - pe_done_q (previous-cycle sample) clears to 0; state goes to ACCUM.
  - Partial rows in progress are lost.
- Edge detect: edge = pe_done & ~pe_done_q.
  - A level held high for many cycles counts once.
  - pe_done already high in the first clock after reset counts as an edge.
- State ACCUM:
  - On edge with row_cnt==0: acc[i] <= pe_out_i.
  - On edge with row_cnt>0: acc[i] <= acc[i] + pe_out_i, unsigned, modulo 2^d_width; any carry-out sets ovf.
  - If the edge occurs with row_cnt==num_rows-1: row_cnt <= 0, idx <= 0, state <= DRAIN.
  - Otherwise the edge increments row_cnt.
  - With num_rows==1, every edge goes straight to DRAIN.
- State DRAIN:
  - out_valid=1, out_data=acc[idx], out_last=(idx==2).
  - Latency: out_valid is high in the cycle immediately after the clock edge that samples the final pe_done edge.
  - Transfer occurs when out_valid & out_ready.
  - Transfer with idx<2: idx++.
  - Transfer with idx==2: state <= ACCUM, out_valid and out_last drop next cycle.
  - With out_ready held high, exactly 3 consecutive valid cycles.
  - While out_valid & ~out_ready, out_data and out_last hold stable.
  - A pe_done edge in DRAIN sets drop and does not modify acc or row_cnt.
- ACCUM outputs: out_valid=0, out_last=0, out_data holds its last value.
- ovf and drop clear only on rst.

Test Plan:
- PE fed iact 2,4,6,8,10 / weights 1,2,3, so pe_out=(28,40,52); three pe_done edges with num_rows=3 and out_ready=1 -> out_data 84,120,156 on three consecutive valid cycles, out_last only with 156, ovf=0, drop=0.
- Same stimulus, out_ready low for 4 cycles after out_valid rises, then toggled 1/0 -> out_data holds 84 while stalled; each of 84,120,156 transferred exactly once, in order.
- pe_done held high 5 cycles with pe_out=(28,40,52) -> one accumulation only; row_cnt=1, busy=1, out_valid=0.
- num_rows=2, row 1 pe_out0=0xFFFFFFFF, row 2 pe_out0=2 -> first word 0x00000001 and ovf=1 and stays 1; other words unaffected.
- pe_done edge injected while DRAIN is stalled -> drop=1, drained words unchanged (84,120,156); the next three edges of (1,1,1) give 3,3,3.
- Assert rst asynchronously after 2 of 3 rows -> all outputs 0 immediately, before the next clk edge; three fresh rows of (28,40,52) then give 84,120,156.

Source files
------------

// File: rtl/psum_row_accumulator.sv
// psum_row_accumulator
//   Captures the three partial sums of the 1-D convolution PE on every rising
//   edge of pe_done. It sums them element-wise over num_rows passes, then
//   streams the finished row (3 words) over a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   pe_done    PE done level; its rising edge marks pe_out0..2 valid
//   pe_out0..2 PE partial sums for output positions 0..2
//   out_data   accumulated output word (holds its last value while idle)
//   out_valid  out_data valid
//   out_ready  consumer accepts out_data
//   out_last   high with the final word (position 2) of a row
//   busy       a row is partially accumulated, or a row is draining
//   ovf        sticky: an accumulation carried out of d_width
//   drop       sticky: a pe_done edge arrived while draining and was discarded
module psum_row_accumulator #(
    parameter int d_width  = 32,
    parameter int num_rows = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pe_done,
    input  logic [d_width-1:0] pe_out0,
    input  logic [d_width-1:0] pe_out1,
    input  logic [d_width-1:0] pe_out2,
    output logic [d_width-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               ovf,
    output logic               drop
);

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [d_width-1:0] acc [3];
    logic [d_width-1:0] pe_out [3];
    logic [d_width:0]   sum [3];
    logic [d_width-1:0] data_q;
    logic [d_width-1:0] acc_sel;
    logic [7:0]         row_cnt;
    logic [1:0]         idx;
    logic               pe_done_q;
    logic               pe_edge;
    logic               last_row;
    logic               xfer;
    logic               carry;

    assign pe_out[0] = pe_out0;
    assign pe_out[1] = pe_out1;
    assign pe_out[2] = pe_out2;

    // Level held high counts once; pe_done_q resets low, so a level already
    // high in the first clock after reset is seen as an edge.
    assign pe_edge  = pe_done & ~pe_done_q;
    assign last_row = (row_cnt == 8'(num_rows - 1));
    assign xfer     = out_valid & out_ready;
    assign busy     = (row_cnt != 8'd0) || (state == DRAIN);

    // Unsigned sums with an extra bit to catch the carry-out.
    always_comb begin
        carry = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            sum[i] = {1'b0, acc[i]} + {1'b0, pe_out[i]};
            carry  = carry | sum[i][d_width];
        end
    end

    always_comb begin
        case (idx)
            2'd0:    acc_sel = acc[0];
            2'd1:    acc_sel = acc[1];
            default: acc_sel = acc[2];
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next state and outputs
    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = data_q;
        case (state)
            ACCUM: begin
                if (pe_edge && last_row) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = (idx == 2'd2);
                out_data  = acc_sel;
                if (out_ready && idx == 2'd2) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    // Datapath. data_q shadows the word on the bus while draining so that
    // out_data keeps the last drained value once acc is reused in ACCUM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 3; i++) begin
                acc[i] <= '0;
            end
            data_q    <= '0;
            row_cnt   <= '0;
            idx       <= '0;
            pe_done_q <= 1'b0;
            ovf       <= 1'b0;
            drop      <= 1'b0;
        end else begin
            pe_done_q <= pe_done;
            if (state == DRAIN) begin
                data_q <= acc_sel;
                if (pe_edge) begin
                    drop <= 1'b1;
                end
                if (xfer && idx != 2'd2) begin
                    idx <= idx + 2'd1;
                end
            end else if (pe_edge) begin
                for (int unsigned i = 0; i < 3; i++) begin
                    if (row_cnt == 8'd0) begin
                        acc[i] <= pe_out[i];
                    end else begin
                        acc[i] <= sum[i][d_width-1:0];
                    end
                end
                if (row_cnt != 8'd0 && carry) begin
                    ovf <= 1'b1;
                end
                if (last_row) begin
                    row_cnt <= '0;
                    idx     <= '0;
                end else begin
                    row_cnt <= row_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_psum_row_accumulator.sv
module tb_psum_row_accumulator;

    logic        clk;
    logic        rst;
    logic        pe_done;
    logic [31:0] pe_out0;
    logic [31:0] pe_out1;
    logic [31:0] pe_out2;
    logic        out_ready;

    logic [31:0] out_data3;
    logic        out_valid3;
    logic        out_last3;
    logic        busy3;
    logic        ovf3;
    logic        drop3;

    logic [31:0] out_data2;
    logic        out_valid2;
    logic        out_last2;
    logic        busy2;
    logic        ovf2;
    logic        drop2;

    int checks = 0;
    int errors = 0;

    logic mon3_en = 1'b1;
    logic mon2_en = 1'b0;

    // Scoreboards: {last, data}
    logic [32:0] q3 [$];
    logic [32:0] q2 [$];

    psum_row_accumulator #(.d_width(32), .num_rows(3)) dut3 (
        .clk(clk), .rst(rst), .pe_done(pe_done),
        .pe_out0(pe_out0), .pe_out1(pe_out1), .pe_out2(pe_out2),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready),
        .out_last(out_last3), .busy(busy3), .ovf(ovf3), .drop(drop3)
    );

    psum_row_accumulator #(.d_width(32), .num_rows(2)) dut2 (
        .clk(clk), .rst(rst), .pe_done(pe_done),
        .pe_out0(pe_out0), .pe_out1(pe_out1), .pe_out2(pe_out2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
        .out_last(out_last2), .busy(busy2), .ovf(ovf2), .drop(drop2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: inputs change just after posedge, so at negedge both
    // DUT outputs and out_ready are settled for the coming edge.
    always @(negedge clk) begin
        if (mon3_en && out_valid3) begin
            checks++;
            assert (q3.size() != 0) else begin
                errors++;
                $error("FAIL dut3_unexpected_valid observed=%0h expected=none", out_data3);
            end
            if (q3.size() != 0) begin
                chk("dut3_word", {out_last3, out_data3}, q3[0]);
                if (out_ready) void'(q3.pop_front());
            end
        end
        if (mon2_en && out_valid2) begin
            checks++;
            assert (q2.size() != 0) else begin
                errors++;
                $error("FAIL dut2_unexpected_valid observed=%0h expected=none", out_data2);
            end
            if (q2.size() != 0) begin
                chk("dut2_word", {out_last2, out_data2}, q2[0]);
                if (out_ready) void'(q2.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // One pe_done pulse; returns one cycle after the sampling edge.
    task automatic pulse(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        step();
        pe_out0 = a;
        pe_out1 = b;
        pe_out2 = c;
        pe_done = 1'b1;
        step();
        pe_done = 1'b0;
    endtask

    task automatic push3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        q3.push_back({1'b0, a});
        q3.push_back({1'b0, b});
        q3.push_back({1'b1, c});
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((q3.size() != 0 || q2.size() != 0) && n < 60) begin
            step();
            n++;
        end
        chk(tag, 33'(q3.size() + q2.size()), 33'd0);
    endtask

    initial begin
        int vcnt;
        rst = 1'b0;
        pe_done = 1'b0;
        pe_out0 = '0;
        pe_out1 = '0;
        pe_out2 = '0;
        out_ready = 1'b1;

        // Reset state
        do_reset();
        chk("rst_valid", 33'(out_valid3), 33'd0);
        chk("rst_data", 33'(out_data3), 33'd0);
        chk("rst_busy", 33'(busy3), 33'd0);
        chk("rst_flags", 33'({ovf3, drop3, out_last3}), 33'd0);

        // Basic row, ready held high: exactly three consecutive valid cycles
        push3(32'd84, 32'd120, 32'd156);
        pulse(32'd28, 32'd40, 32'd52);
        chk("row_busy", 33'(busy3), 33'd1);
        pulse(32'd28, 32'd40, 32'd52);
        pulse(32'd28, 32'd40, 32'd52);
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid3) vcnt++;
            step();
        end
        chk("valid_cycles", 33'(vcnt), 33'd3);
        wait_drain("drain1");
        chk("flags1", 33'({ovf3, drop3}), 33'd0);
        chk("idle_hold", 33'(out_data3), 33'd156);

        // Backpressure: stall 4 cycles then toggle ready
        out_ready = 1'b0;
        push3(32'd84, 32'd120, 32'd156);
        pulse(32'd28, 32'd40, 32'd52);
        pulse(32'd28, 32'd40, 32'd52);
        pulse(32'd28, 32'd40, 32'd52);
        repeat (4) step();
        chk("stall_data", 33'(out_data3), 33'd84);
        for (int i = 0; i < 12; i++) begin
            out_ready = (i % 2 == 0);
            step();
        end
        out_ready = 1'b1;
        wait_drain("drain2");

        // pe_done held high 5 cycles counts once
        step();
        pe_out0 = 32'd28;
        pe_out1 = 32'd40;
        pe_out2 = 32'd52;
        pe_done = 1'b1;
        repeat (5) step();
        pe_done = 1'b0;
        step();
        chk("level_rowcnt", 33'(dut3.row_cnt), 33'd1);
        chk("level_busy", 33'(busy3), 33'd1);
        chk("level_valid", 33'(out_valid3), 33'd0);

        // Overflow on the num_rows=2 instance
        do_reset();
        mon3_en = 1'b0;
        mon2_en = 1'b1;
        q2.push_back({1'b0, 32'h0000_0001});
        q2.push_back({1'b0, 32'd80});
        q2.push_back({1'b1, 32'd104});
        pulse(32'hFFFF_FFFF, 32'd40, 32'd52);
        chk("ovf_before", 33'(ovf2), 33'd0);
        pulse(32'd2, 32'd40, 32'd52);
        chk("ovf_set", 33'(ovf2), 33'd1);
        wait_drain("drain_ovf");
        repeat (3) step();
        chk("ovf_sticky", 33'(ovf2), 33'd1);
        mon2_en = 1'b0;
        do_reset();
        mon3_en = 1'b1;

        // Edge during stalled drain is dropped
        out_ready = 1'b0;
        push3(32'd84, 32'd120, 32'd156);
        pulse(32'd28, 32'd40, 32'd52);
        pulse(32'd28, 32'd40, 32'd52);
        pulse(32'd28, 32'd40, 32'd52);
        pulse(32'd5, 32'd5, 32'd5);
        chk("drop_set", 33'(drop3), 33'd1);
        out_ready = 1'b1;
        wait_drain("drain_drop");
        push3(32'd3, 32'd3, 32'd3);
        pulse(32'd1, 32'd1, 32'd1);
        pulse(32'd1, 32'd1, 32'd1);
        pulse(32'd1, 32'd1, 32'd1);
        wait_drain("drain_ones");
        chk("drop_sticky", 33'(drop3), 33'd1);

        // Asynchronous reset mid-row takes effect before the next clock
        pulse(32'd28, 32'd40, 32'd52);
        pulse(32'd28, 32'd40, 32'd52);
        chk("pre_rst_busy", 33'(busy3), 33'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_outs", {out_last3, out_data3}, 33'd0);
        chk("arst_flags", 33'({out_valid3, busy3, ovf3, drop3}), 33'd0);
        step();
        rst = 1'b0;
        step();
        push3(32'd84, 32'd120, 32'd156);
        pulse(32'd28, 32'd40, 32'd52);
        pulse(32'd28, 32'd40, 32'd52);
        pulse(32'd28, 32'd40, 32'd52);
        wait_drain("drain_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
